// File: rtl/delay_meter_pkg.sv
// Shared types and constants for the delay meter: FSM states and the timer's
// {mode_a, mode_b} delay-mode encoding.
package delay_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StMeasure,
    StDone
  } state_e;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ONESHOT = 2'b00;
  localparam mode_t MODE_DLY_OP  = 2'b01;
  localparam mode_t MODE_DLY_REL = 2'b10;
  localparam mode_t MODE_DUAL    = 2'b11;

endpackage

// File: rtl/delay_meter_if.sv
// Signal bundle between the delay meter and whatever drives/observes it.
interface delay_meter_if
  import delay_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 trig_in;
  logic                 dly_in_n;
  logic                 arm;
  logic [CNT_WIDTH-1:0] timeout_val;
  logic                 busy;
  logic                 meas_valid;
  logic [CNT_WIDTH-1:0] rise_delay;
  logic [CNT_WIDTH-1:0] fall_delay;
  logic [CNT_WIDTH-1:0] pulse_width;
  mode_t                mode_code;
  logic                 timeout;

  modport master (
    output trig_in, dly_in_n, arm, timeout_val,
    input  busy, meas_valid, rise_delay, fall_delay, pulse_width, mode_code, timeout
  );

  modport slave (
    input  trig_in, dly_in_n, arm, timeout_val,
    output busy, meas_valid, rise_delay, fall_delay, pulse_width, mode_code, timeout
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser followed by a registered edge detector; level_o is
// delayed to line up with the rise/fall pulses.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      level_q <= sync_out;
      rise_q  <= sync_out & ~level_q;
      fall_q  <= ~sync_out & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/delay_meter.sv
// Measures turn-on delay, turn-off delay and pulse width of a delay timer's
// active-low output relative to its trigger, and classifies the delay mode.
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOL         = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  delay_meter_if.slave meas_io
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t TolCnt = cnt_t'(TOL);

  logic trig_lvl, trig_rise, trig_fall;
  logic dly_n_lvl, dly_n_rise, dly_n_fall;
  logic out_act, out_rise, out_fall;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_trig_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (meas_io.trig_in),
    .level_o(trig_lvl),
    .rise_o (trig_rise),
    .fall_o (trig_fall)
  );

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_dly_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (meas_io.dly_in_n),
    .level_o(dly_n_lvl),
    .rise_o (dly_n_rise),
    .fall_o (dly_n_fall)
  );

  // Only trigger edges matter; its level is intentionally left unused.
  logic unused_trig_lvl;
  assign unused_trig_lvl = trig_lvl;

  assign out_act  = ~dly_n_lvl;
  assign out_rise = dly_n_fall;
  assign out_fall = dly_n_rise;

  state_e state_q, state_d;
  cnt_t   win_cnt_q, win_cnt_d;
  cnt_t   ts_on_q, ts_on_d, ts_fall_q, ts_fall_d, ts_off_q, ts_off_d;
  logic   on_seen_q, on_seen_d, fall_seen_q, fall_seen_d, off_seen_q, off_seen_d;
  logic   meas_done, win_hit, finish;

  cnt_t   rise_q, fall_q, width_q;
  mode_t  mode_q;
  logic   timeout_q;
  cnt_t   res_rise, res_fall, res_width;
  mode_t  res_mode;
  logic   off_before_fall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign meas_done = fall_seen_d && off_seen_d;
  assign win_hit   = (meas_io.timeout_val != '0) && (win_cnt_q == meas_io.timeout_val);

  // Next-state logic; a new arm always wins and discards a run in progress.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (meas_io.arm) state_d = StArmed;
      StArmed:   if (!meas_io.arm && trig_rise) state_d = StMeasure;
      StMeasure: begin
        if (meas_io.arm) begin
          state_d = StArmed;
        end else if (meas_done || win_hit) begin
          state_d = StDone;
        end
      end
      StDone:    state_d = meas_io.arm ? StArmed : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    meas_io.busy       = 1'b0;
    meas_io.meas_valid = 1'b0;
    unique case (state_q)
      StArmed, StMeasure: meas_io.busy       = 1'b1;
      StDone:             meas_io.meas_valid = 1'b1;
      default:            ;
    endcase
  end

  // Event tracker; win_cnt is 0 on the trigger-rise cycle and counts from there.
  always_comb begin
    win_cnt_d   = win_cnt_q;
    ts_on_d     = ts_on_q;
    ts_fall_d   = ts_fall_q;
    ts_off_d    = ts_off_q;
    on_seen_d   = on_seen_q;
    fall_seen_d = fall_seen_q;
    off_seen_d  = off_seen_q;
    unique case (state_q)
      StArmed: begin
        if (!meas_io.arm && trig_rise) begin
          win_cnt_d   = cnt_t'(1);
          ts_on_d     = '0;
          ts_fall_d   = '0;
          ts_off_d    = '0;
          on_seen_d   = out_act;
          fall_seen_d = 1'b0;
          off_seen_d  = 1'b0;
        end
      end
      StMeasure: begin
        if (win_cnt_q != '1) win_cnt_d = win_cnt_q + cnt_t'(1);
        if (out_rise && !on_seen_q) begin
          ts_on_d   = win_cnt_q;
          on_seen_d = 1'b1;
        end
        if (trig_fall && !fall_seen_q) begin
          ts_fall_d   = win_cnt_q;
          fall_seen_d = 1'b1;
        end
        if (out_fall && on_seen_q && !off_seen_q) begin
          ts_off_d   = win_cnt_q;
          off_seen_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= '0;
      ts_on_q     <= '0;
      ts_fall_q   <= '0;
      ts_off_q    <= '0;
      on_seen_q   <= 1'b0;
      fall_seen_q <= 1'b0;
      off_seen_q  <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      ts_on_q     <= ts_on_d;
      ts_fall_q   <= ts_fall_d;
      ts_off_q    <= ts_off_d;
      on_seen_q   <= on_seen_d;
      fall_seen_q <= fall_seen_d;
      off_seen_q  <= off_seen_d;
    end
  end

  // Results use this cycle's events so a completing edge is counted.
  always_comb begin
    res_rise = on_seen_d ? ts_on_d : '0;
    if (off_seen_d) begin
      res_width = ts_off_d - ts_on_d;
    end else if (on_seen_d) begin
      res_width = win_cnt_q - ts_on_d;
    end else begin
      res_width = '0;
    end
    res_fall = (off_seen_d && fall_seen_d && (ts_off_d > ts_fall_d)) ? ts_off_d - ts_fall_d : '0;
    off_before_fall = off_seen_d && (!fall_seen_d || (ts_off_d < ts_fall_d));
    res_mode = {res_fall >= TolCnt, res_rise >= TolCnt};
    if (res_mode == MODE_ONESHOT && !off_before_fall) res_mode = MODE_DLY_REL;
  end

  assign finish = (state_q == StMeasure) && (state_d == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q    <= '0;
      fall_q    <= '0;
      width_q   <= '0;
      mode_q    <= MODE_ONESHOT;
      timeout_q <= 1'b0;
    end else if (finish) begin
      rise_q    <= res_rise;
      fall_q    <= res_fall;
      width_q   <= res_width;
      mode_q    <= res_mode;
      timeout_q <= !meas_done;
    end
  end

  assign meas_io.rise_delay  = rise_q;
  assign meas_io.fall_delay  = fall_q;
  assign meas_io.pulse_width = width_q;
  assign meas_io.mode_code   = mode_q;
  assign meas_io.timeout     = timeout_q;

endmodule

// File: tb/tb_delay_meter.sv
// Self-checking bench for delay_meter: directed table, randomized waveforms
// against an event-time model, plus abort and mid-run reset sequences.
module tb_delay_meter;
  import delay_meter_pkg::*;

  localparam int unsigned SyncStages = 2;
  localparam int          Lat        = SyncStages + 2;
  localparam int          Never      = -1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delay_meter_if #(.CNT_WIDTH(16)) dm_if ();

  delay_meter #(
    .CNT_WIDTH  (16),
    .SYNC_STAGES(SyncStages),
    .TOL        (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .meas_io(dm_if)
  );

  // Event offsets are in cycles after the trigger rise at the pins.
  typedef struct {
    int on_at;
    int tw;
    int off_at;
    int tv;
    int rise;
    int fall;
    int width;
    int mode;
    int to;
    int end_t;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dm_if.trig_in  = 1'b0;
    dm_if.dly_in_n = 1'b1;
    dm_if.arm      = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_arm();
    dm_if.arm = 1'b1;
    tick();
    dm_if.arm = 1'b0;
  endtask

  // Reference: which events fall inside the window, then the result rules.
  function automatic vec_t model(input int on_at, input int tw, input int off_at, input int tv);
    vec_t r;
    int   comp;
    bit   on_s, fall_s, off_s;
    r.on_at = on_at; r.tw = tw; r.off_at = off_at; r.tv = tv;
    comp = (off_at >= 0) ? ((off_at > tw) ? off_at : tw) : 32'h3fff_ffff;
    if (tv != 0 && tv < comp) begin
      r.end_t = tv; r.to = 1;
    end else begin
      r.end_t = comp; r.to = 0;
    end
    on_s   = (on_at >= 0) && (on_at <= r.end_t);
    fall_s = tw <= r.end_t;
    off_s  = on_s && (off_at >= 0) && (off_at <= r.end_t);
    r.rise  = on_s ? on_at : 0;
    r.width = off_s ? off_at - on_at : (on_s ? r.end_t - on_at : 0);
    r.fall  = (off_s && fall_s && off_at > tw) ? off_at - tw : 0;
    r.mode  = ((r.fall >= 4) ? 2 : 0) + ((r.rise >= 4) ? 1 : 0);
    if (r.mode == 0 && !(off_s && (!fall_s || off_at < tw))) r.mode = 2;
    return r;
  endfunction

  // Plays one waveform (DUT must already be armed) and checks the result.
  task automatic run(input vec_t v, input string tag);
    int seen;
    int limit;
    seen  = -1;
    limit = v.end_t + Lat + 8;
    dm_if.timeout_val = 16'(v.tv);
    for (int t = 0; t <= limit; t++) begin
      tick();
      if (dm_if.meas_valid === 1'b1) begin
        seen = t;
        break;
      end
      dm_if.trig_in  = (t < v.tw);
      dm_if.dly_in_n = !(v.on_at >= 0 && t >= v.on_at && (v.off_at < 0 || t < v.off_at));
    end
    check({tag, "_valid_cycle"}, seen, v.end_t + Lat);
    check({tag, "_rise"}, dm_if.rise_delay, v.rise);
    check({tag, "_fall"}, dm_if.fall_delay, v.fall);
    check({tag, "_width"}, dm_if.pulse_width, v.width);
    check({tag, "_mode"}, dm_if.mode_code, v.mode);
    check({tag, "_timeout"}, dm_if.timeout, v.to);
    check({tag, "_busy"}, dm_if.busy, 0);
    idle(3);
    check({tag, "_hold"}, {dm_if.rise_delay, dm_if.pulse_width}, {16'(v.rise), 16'(v.width)});
    idle(4);
  endtask

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_valid, busy_drop;
    vec_t v;

    tbl[0] = '{2, 30, 12, 0, 2, 0, 10, 0, 0, 30};
    tbl[1] = '{40, 100, 102, 0, 40, 2, 62, 1, 0, 102};
    tbl[2] = '{1, 50, 90, 0, 1, 40, 89, 2, 0, 90};
    tbl[3] = '{20, 60, 80, 0, 20, 20, 60, 3, 0, 80};
    tbl[4] = '{Never, 200, Never, 100, 0, 0, 0, 2, 1, 100};
    tbl[5] = '{0, 20, 20, 0, 0, 0, 20, 2, 0, 20};
    tbl[6] = '{4, 10, 13, 0, 4, 3, 9, 1, 0, 13};
    tbl[7] = '{3, 10, 14, 0, 3, 4, 11, 2, 0, 14};
    tbl[8] = '{10, 200, Never, 50, 10, 0, 40, 1, 1, 50};
    tbl[9] = '{5, 30, 40, 40, 5, 10, 35, 3, 0, 40};

    dm_if.timeout_val = '0;
    idle(3);
    check("reset_outputs",
          {dm_if.busy, dm_if.meas_valid, dm_if.rise_delay, dm_if.fall_delay,
           dm_if.pulse_width, dm_if.mode_code, dm_if.timeout}, '0);
    rst_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      do_arm();
      check($sformatf("tbl%0d_armed_busy", i), dm_if.busy, 1);
      idle(2);
      run(tbl[i], $sformatf("tbl%0d", i));
    end

    // Re-arm mid-measurement: old run must vanish, next rise is measured.
    do_arm();
    idle(2);
    saw_valid = 1'b0;
    busy_drop = 1'b0;
    for (int t = 0; t < 32; t++) begin
      tick();
      saw_valid |= dm_if.meas_valid;
      busy_drop |= !dm_if.busy;
      dm_if.arm      = (t == 10);
      dm_if.trig_in  = (t < 20);
      dm_if.dly_in_n = !(t >= 5 && t < 15);
    end
    check("abort_no_valid", saw_valid, 0);
    check("abort_busy_held", busy_drop, 0);
    idle(6);
    check("abort_still_armed", dm_if.busy, 1);
    run(tbl[0], "after_abort");

    // Reset in the middle of a measurement.
    do_arm();
    idle(2);
    for (int t = 0; t < 12; t++) begin
      tick();
      dm_if.trig_in  = 1'b1;
      dm_if.dly_in_n = !(t >= 3);
    end
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs",
          {dm_if.busy, dm_if.meas_valid, dm_if.rise_delay, dm_if.fall_delay,
           dm_if.pulse_width, dm_if.mode_code, dm_if.timeout}, '0);
    tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    busy_drop = 1'b0;
    for (int t = 13; t < 45; t++) begin
      tick();
      saw_valid |= dm_if.meas_valid;
      busy_drop |= dm_if.busy;
      dm_if.trig_in  = (t < 20);
      dm_if.dly_in_n = !(t >= 3 && t < 25);
    end
    check("reset_mid_no_valid", saw_valid, 0);
    check("reset_mid_idle", busy_drop, 0);
    idle(4);

    for (int i = 0; i < 24; i++) begin
      int on_at, off_at, tw, tv;
      on_at  = int'($urandom_range(0, 30));
      off_at = on_at + int'($urandom_range(1, 40));
      tw     = int'($urandom_range(1, 60));
      tv     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 80)) : 0;
      v = model(on_at, tw, off_at, tv);
      do_arm();
      idle(2);
      run(v, $sformatf("rnd%0d_on%0d_tw%0d_off%0d_tv%0d", i, on_at, tw, off_at, tv));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
